// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler: round-robin share of one calibrator across NUM_CH channels feeding a single DAC serializer.
// Define CAL_PIPE_EN for a registered (one-cycle latency) calibrator; default is combinational.
module dac_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int N      = 16,
  parameter int M      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_valid,
  output logic [NUM_CH-1:0]   ch_ready,
  input  logic [NUM_CH*N-1:0] ch_volts,
  output logic [N-1:0]        cal_in,
  input  logic [M-1:0]        cal_word,
  output logic                dac_valid,
  input  logic                dac_ready,
  output logic [CH_W-1:0]     dac_addr,
  output logic [M-1:0]        dac_word,
  output logic                busy
);
`ifdef CAL_PIPE_EN
  typedef enum logic [1:0] {IDLE, CAL, CAL_WAIT, SEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, CAL, SEND} state_t;
`endif
  state_t state, state_nxt;
  logic [N-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0] rr_ptr, grant, arb, idx;
  logic found, last_cal, cal_active;
`ifdef CAL_PIPE_EN
  assign last_cal   = state == CAL_WAIT;
  assign cal_active = state == CAL || state == CAL_WAIT;
`else
  assign last_cal   = state == CAL;
  assign cal_active = state == CAL;
`endif
  assign ch_ready  = ~pending;
  assign dac_valid = state == SEND;
  assign busy      = state != IDLE || |pending;
  assign cal_in    = cal_active ? hold[grant] : '0;
  // Scan downward so the pending channel closest above rr_ptr wins last.
  always_comb begin
    arb   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (pending[idx]) begin
        arb   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = found ? CAL : IDLE;
`ifdef CAL_PIPE_EN
      CAL:      state_nxt = CAL_WAIT;
      CAL_WAIT: state_nxt = SEND;
`else
      CAL:      state_nxt = SEND;
`endif
      SEND:     state_nxt = dac_ready ? IDLE : SEND;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      dac_addr <= '0;
      dac_word <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending | ch_valid) & ~({{(NUM_CH-1){1'b0}}, last_cal} << grant);
      if (state == IDLE && found) begin
        grant  <= arb;
        rr_ptr <= (arb == CH_W'(NUM_CH - 1)) ? '0 : arb + 1'b1;
      end
      if (last_cal) begin
        dac_word <= cal_word;
        dac_addr <= grant;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (rst_n && ch_valid[i] && !pending[i]) hold[i] <= ch_volts[i*N +: N];
  end
endmodule

// File: tb/tb_dac_channel_scheduler.sv
// tb_dac_channel_scheduler: directed checks of reset, latency, round-robin order, back-pressure and mid-transfer reset.
module tb_dac_channel_scheduler;
  localparam int NUM_CH = 4, CH_W = 2, N = 16, M = 12;
`ifdef CAL_PIPE_EN
  localparam int LAT = 3, PER = 4;
`else
  localparam int LAT = 2, PER = 3;
`endif
  logic clk = 1'b0, rst_n;
  logic [NUM_CH-1:0] ch_valid, ch_ready;
  logic [NUM_CH*N-1:0] ch_volts;
  logic [N-1:0] cal_in;
  logic [M-1:0] cal_word;
  logic dac_valid, dac_ready, busy;
  logic [CH_W-1:0] dac_addr;
  logic [M-1:0] dac_word;
  int n_tests = 0, n_fail = 0, n_ev;
  int ev_addr [16], ev_word [16], ev_cyc [16];
  dac_channel_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_volts(ch_volts),
    .cal_in(cal_in), .cal_word(cal_word), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .dac_addr(dac_addr), .dac_word(dac_word), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] calib(input logic [15:0] v);
    int t;
    t = 2048 + (int'($signed(v)) >>> 4);
    return t[11:0];
  endfunction
`ifdef CAL_PIPE_EN
  logic [11:0] cal_q = '0;
  always_ff @(posedge clk) cal_q <= calib(cal_in);
  assign cal_word = cal_q;
`else
  assign cal_word = calib(cal_in);
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    ch_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic set_volts(input int ch, input int v);
    ch_volts[ch*N +: N] = N'(v);
  endtask
  task automatic send(input logic [NUM_CH-1:0] m);
    ch_valid = m;
    tick();
    ch_valid = '0;
  endtask
  task automatic wait_valid(input string tag, input int c0);
    int c = c0;
    while (dac_valid !== 1'b1 && c < 30) begin
      tick();
      c++;
    end
    check({tag, "_lat"}, c, LAT);
  endtask
  task automatic collect(input int ncyc);
    n_ev = 0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (dac_valid === 1'b1 && n_ev < 16) begin
        ev_addr[n_ev] = int'(dac_addr);
        ev_word[n_ev] = int'(dac_word);
        ev_cyc[n_ev]  = c;
        n_ev++;
      end
    end
  endtask
  task automatic check_rr(input string tag, input int sgn);
    check({tag, "_count"}, n_ev, 4);
    for (int k = 0; k < 4 && k < n_ev; k++) begin
      check($sformatf("%s_addr%0d", tag, k), ev_addr[k], k);
      check($sformatf("%s_word%0d", tag, k), ev_word[k], 2048 + sgn * 4 * k);
      check($sformatf("%s_cyc%0d", tag, k), ev_cyc[k], LAT + k * PER);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    ch_valid = '1;
    ch_volts = '0;
    dac_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_ready", ch_ready, 4'hF);
    check("rst_valid", dac_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", dac_addr, 0);
    check("rst_word", dac_word, 0);
    ch_valid = '0;
    rst_n = 1'b1;
    tick();
    check("rst_nocap_busy", busy, 0);
    check("rst_nocap_ready", ch_ready, 4'hF);
    set_volts(1, 0);
    send(4'b0010);
    check("single_ready", ch_ready, 4'b1101);
    check("single_busy", busy, 1);
    wait_valid("single", 0);
    check("single_addr", dac_addr, 1);
    check("single_word", dac_word, 2048);
    tick();
    check("single_pulse", dac_valid, 0);
    check("single_idle", busy, 0);
    set_volts(3, 160);
    send(4'b1000);
    tick();
    check("single3_cal_in", cal_in, 160);
    wait_valid("single3", 1);
    check("single3_addr", dac_addr, 3);
    check("single3_word", dac_word, 2058);
    tick();
    check("single3_cal_in_idle", cal_in, 0);
    do_reset();
    for (int i = 0; i < 4; i++) set_volts(i, i * 64);
    send(4'hF);
    collect(4 * PER);
    check_rr("rr1", 1);
    for (int i = 0; i < 4; i++) set_volts(i, -i * 64);
    send(4'hF);
    collect(4 * PER);
    check_rr("rr2", -1);
    do_reset();
    dac_ready = 1'b0;
    set_volts(0, -320);
    send(4'b0001);
    wait_valid("bp", 0);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", dac_valid, 1);
      check("bp_word", dac_word, 2028);
      check("bp_addr", dac_addr, 0);
      if (i == 3) begin
        check("bp_ready_free", ch_ready, 4'hF);
        set_volts(2, 480);
        set_volts(0, 16);
        ch_valid = 4'b0101;
      end
      tick();
      ch_valid = '0;
      if (i == 3) check("bp_ready_taken", ch_ready, 4'b1010);
    end
    dac_ready = 1'b1;
    tick();
    wait_valid("bp_ch2", 0);
    check("bp_ch2_addr", dac_addr, 2);
    check("bp_ch2_word", dac_word, 2078);
    tick();
    wait_valid("bp_ch0", 0);
    check("bp_ch0_addr", dac_addr, 0);
    check("bp_ch0_word", dac_word, 2049);
    tick();
    do_reset();
    dac_ready = 1'b0;
    send(4'b1010);
    wait_valid("mr", 0);
    check("mr_first_addr", dac_addr, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid", dac_valid, 0);
    check("mr_ready", ch_ready, 4'hF);
    check("mr_busy", busy, 0);
    dac_ready = 1'b1;
    set_volts(0, 0);
    set_volts(3, 0);
    send(4'b1001);
    collect(2 * PER);
    check("mr_count", n_ev, 2);
    check("mr_ptr_first", ev_addr[0], 0);
    check("mr_ptr_second", ev_addr[1], 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
